// File: rtl/rle_decode.sv
// Run-length decoder: reads (count,value) byte pairs from a single-port SRAM and
// writes the expanded byte stream back as little-endian packed 32-bit words.
module rle_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rle_addr,
  input  logic [31:0] rle_size,
  input  logic [31:0] message_addr,
  output logic [31:0] message_size,
  output logic        done,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out
);

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, EXPAND, WRITE, FLUSH, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rd_ptr_q, rd_ptr_d;
  logic [31:0] wr_ptr_q, wr_ptr_d;
  logic [31:0] msize_q, msize_d;
  logic [30:0] pairs_left_q, pairs_left_d;
  logic [31:8] word_q, word_d;
  logic        half_q, half_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        done_q, done_d;

  logic [7:0]  cur_val;
  logic        last_pair;

  assign cur_val   = half_q ? word_q[31:24] : word_q[15:8];
  assign last_pair = (pairs_left_q == 31'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      msize_q      <= '0;
      pairs_left_q <= '0;
      word_q       <= '0;
      half_q       <= 1'b0;
      cnt_q        <= '0;
      buf_q        <= '0;
      nbytes_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      msize_q      <= msize_d;
      pairs_left_q <= pairs_left_d;
      word_q       <= word_d;
      half_q       <= half_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      nbytes_q     <= nbytes_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    msize_d      = msize_q;
    pairs_left_d = pairs_left_q;
    word_d       = word_q;
    half_d       = half_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    nbytes_d     = nbytes_q;
    done_d       = done_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d     = rle_addr;
          wr_ptr_d     = message_addr;
          msize_d      = '0;
          pairs_left_d = rle_size[31:1];
          half_d       = 1'b0;
          cnt_d        = '0;
          buf_d        = '0;
          nbytes_d     = '0;
          done_d       = 1'b0;
          state_d      = (rle_size[31:1] == 31'd0) ? FINISH : READ;
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        word_d   = port_A_data_out[31:8];
        cnt_d    = port_A_data_out[7:0];
        half_d   = 1'b0;
        rd_ptr_d = rd_ptr_q + 32'd4;
        state_d  = EXPAND;
      end
      EXPAND: begin
        if (cnt_q != 8'd0) begin
          buf_d[{nbytes_q[1:0], 3'b000} +: 8] = cur_val;
          nbytes_d = nbytes_q + 3'd1;
          cnt_d    = cnt_q - 8'd1;
          msize_d  = msize_q + 32'd1;
          // Jump straight to FLUSH on the final byte so done follows the last write.
          if (nbytes_q == 3'd3)
            state_d = WRITE;
          else if (cnt_q == 8'd1 && last_pair)
            state_d = FLUSH;
        end else begin
          pairs_left_d = pairs_left_q - 31'd1;
          if (last_pair)
            state_d = (nbytes_q != 3'd0) ? FLUSH : FINISH;
          else if (!half_q) begin
            half_d = 1'b1;
            cnt_d  = word_q[23:16];
          end else
            state_d = READ;
        end
      end
      WRITE: begin
        wr_ptr_d = wr_ptr_q + 32'd4;
        buf_d    = '0;
        nbytes_d = '0;
        state_d  = (cnt_q == 8'd0 && last_pair) ? FINISH : EXPAND;
      end
      FLUSH: begin
        wr_ptr_d = wr_ptr_q + 32'd4;
        buf_d    = '0;
        nbytes_d = '0;
        state_d  = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == FINISH)
      done_d = 1'b1;
  end

  assign port_A_clk     = clk;
  assign port_A_we      = (state_q == WRITE) || (state_q == FLUSH);
  assign port_A_addr    = port_A_we ? wr_ptr_q[15:0] : rd_ptr_q[15:0];
  assign port_A_data_in = buf_q;
  assign message_size   = msize_q;
  assign done           = done_q;

  logic unused_bits;
  assign unused_bits = ^{rle_size[0], rd_ptr_q[31:16], wr_ptr_q[31:16]};

endmodule
